// File: rtl/mini_src_pkg.sv
// Shared opcode, state and IR-field definitions for the Mini-SRC control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mini_src_pkg;

    // Opcode field geometry: IR[31:27]
    localparam int OPW    = 5;
    localparam int RSW    = 4;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = OP_MSB - OPW + 1;

    // Register-select fields follow the opcode, each RSW wide.
    // The sequencer only drives Gra/Grb/Grc; the datapath does the slicing.
    localparam int RA_MSB = OP_LSB - 1;
    localparam int RB_MSB = RA_MSB - RSW;
    localparam int RC_MSB = RB_MSB - RSW;

    // Binary ALU group
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
    // Wide-result group (HI/LO)
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    // Unary group
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    // Control
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    // Instruction class produced by the opcode decoder; exactly one bit set.
    typedef struct packed {
        logic is_bin;
        logic is_muldiv;
        logic is_unary;
        logic is_nop;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

    function automatic logic [OPW-1:0] ir_opcode(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/mini_src_op_decode.sv
// Combinational opcode classifier: IR[31:27] -> one-hot instruction class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
// Ports: i_op (opcode field), o_cls (class flags, exactly one set).
module mini_src_op_decode
    import mini_src_pkg::*;
(
    input  logic [OPW-1:0] i_op,
    output op_class_t      o_cls
);

    always_comb begin
        o_cls = '0;
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: o_cls.is_bin    = 1'b1;
            OP_MUL, OP_DIV:                  o_cls.is_muldiv = 1'b1;
            OP_NEG, OP_NOT:                  o_cls.is_unary  = 1'b1;
            OP_NOP:                          o_cls.is_nop    = 1'b1;
            OP_HALT:                         o_cls.is_halt   = 1'b1;
            default:                         o_cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hard-wired T0..T6 fetch/execute sequencer generating Mini-SRC datapath strobes.
// Latency: binary 6, mul/div 7, unary 5, nop/illegal 4 cycles, plus memory wait cycles in T1.
// Backpressure: run gates fetch in T0; mem_ready=0 holds the sequencer in T1.
// Ports: clock/clear (async active-low), run, IR, mem_ready in; bus-drive strobes
//   (PCout..Rout), register-load strobes (MARin..Zlowin), IncPC, Read, Gra/Grb/Grc,
//   opcode (ALU op during ALU steps), halted, illegal out.
module mini_src_control_unit
    import mini_src_pkg::*;
(
    input  logic           clock,
    input  logic           clear,
    input  logic           run,
    input  logic [31:0]    IR,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           Rout,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Rin,
    output logic           HIin,
    output logic           LOin,
    output logic           Zhighin,
    output logic           Zlowin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic [OPW-1:0] opcode,
    output logic           halted,
    output logic           illegal
);

    state_t          r_state;
    logic            r_t1_seen;   // set once T1 has lasted at least one cycle
    logic [OPW-1:0]  w_op;
    op_class_t       w_cls;
    logic            w_alu_two_op;
    logic            w_ir_unused;

    assign w_op = ir_opcode(IR);

    // Register-select fields are consumed by the datapath's select-encode logic.
    assign w_ir_unused = ^IR[RA_MSB:0] ^ ^IR[RB_MSB:RC_MSB];

    mini_src_op_decode u_op_decode (
        .i_op  (w_op),
        .o_cls (w_cls)
    );

    // mul/div share the binary T3/T4 operand steps.
    assign w_alu_two_op = w_cls.is_bin | w_cls.is_muldiv;

    // State register and next-state logic.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_RESET;
            r_t1_seen <= 1'b0;
        end else begin
            r_t1_seen <= (r_state == S_T1);
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= run ? S_T1 : S_T0;
                S_T1:    r_state <= mem_ready ? S_T2 : S_T1;
                S_T2:    r_state <= S_T3;
                S_T3: begin
                    if (w_alu_two_op || w_cls.is_unary) r_state <= S_T4;
                    else if (w_cls.is_halt)             r_state <= S_HALT;
                    else                                r_state <= S_T0;
                end
                S_T4:    r_state <= w_alu_two_op ? S_T5 : S_T0;
                S_T5:    r_state <= w_cls.is_muldiv ? S_T6 : S_T0;
                S_T6:    r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    // Output decode. Steps from T3 on also look at IR, which is stable from
    // T3 until the next IRin; T0 is qualified by run so an idle T0 is silent.
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        Rout     = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Rin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Zhighin  = 1'b0;
        Zlowin   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        opcode   = '0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_T0: begin
                if (run) begin
                    PCout  = 1'b1;
                    MARin  = 1'b1;
                    IncPC  = 1'b1;
                    Zlowin = 1'b1;
                end
            end
            S_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // Load PC only on the first T1 cycle so wait states don't re-increment.
                PCin    = ~r_t1_seen;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (w_alu_two_op) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (w_cls.is_unary) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    opcode = w_op;
                    Zlowin = 1'b1;
                end else if (w_cls.is_illegal) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (w_alu_two_op) begin
                    Grc     = 1'b1;
                    Rout    = 1'b1;
                    opcode  = w_op;
                    Zhighin = 1'b1;
                    Zlowin  = 1'b1;
                end else if (w_cls.is_unary) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            S_T5: begin
                if (w_cls.is_bin) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (w_cls.is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                if (w_cls.is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
module tb_mini_src_control_unit;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        mem_ready;
    logic PCout, Zhighout, Zlowout, MDRout, Rout;
    logic MARin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, Zhighin, Zlowin;
    logic IncPC, Read, Gra, Grb, Grc, halted, illegal;
    logic [4:0] opcode;

    mini_src_control_unit dut (
        .clock(clock), .clear(clear), .run(run), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .opcode(opcode), .halted(halted), .illegal(illegal)
    );

    // Output vector layout (MSB..LSB):
    // PCout Zhighout Zlowout MDRout Rout MARin PCin MDRin IRin Yin Rin HIin LOin
    // Zhighin Zlowin IncPC Read Gra Grb Grc opcode[4:0] halted illegal
    localparam logic [26:0] M_PCOUT   = 27'd1 << 26;
    localparam logic [26:0] M_ZHOUT   = 27'd1 << 25;
    localparam logic [26:0] M_ZLOUT   = 27'd1 << 24;
    localparam logic [26:0] M_MDROUT  = 27'd1 << 23;
    localparam logic [26:0] M_ROUT    = 27'd1 << 22;
    localparam logic [26:0] M_MARIN   = 27'd1 << 21;
    localparam logic [26:0] M_PCIN    = 27'd1 << 20;
    localparam logic [26:0] M_MDRIN   = 27'd1 << 19;
    localparam logic [26:0] M_IRIN    = 27'd1 << 18;
    localparam logic [26:0] M_YIN     = 27'd1 << 17;
    localparam logic [26:0] M_RIN     = 27'd1 << 16;
    localparam logic [26:0] M_HIIN    = 27'd1 << 15;
    localparam logic [26:0] M_LOIN    = 27'd1 << 14;
    localparam logic [26:0] M_ZHIN    = 27'd1 << 13;
    localparam logic [26:0] M_ZLIN    = 27'd1 << 12;
    localparam logic [26:0] M_INCPC   = 27'd1 << 11;
    localparam logic [26:0] M_READ    = 27'd1 << 10;
    localparam logic [26:0] M_GRA     = 27'd1 << 9;
    localparam logic [26:0] M_GRB     = 27'd1 << 8;
    localparam logic [26:0] M_GRC     = 27'd1 << 7;
    localparam logic [26:0] M_HALTED  = 27'd1 << 1;
    localparam logic [26:0] M_ILLEGAL = 27'd1;

    localparam logic [26:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
    localparam logic [26:0] E_T1F = M_ZLOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [26:0] E_T1W = M_ZLOUT | M_READ | M_MDRIN;
    localparam logic [26:0] E_T2  = M_MDROUT | M_IRIN;
    localparam logic [26:0] E_BT3 = M_GRB | M_ROUT | M_YIN;
    localparam logic [26:0] E_BT4 = M_GRC | M_ROUT | M_ZHIN | M_ZLIN;
    localparam logic [26:0] E_WB  = M_ZLOUT | M_GRA | M_RIN;
    localparam logic [26:0] E_MT5 = M_ZLOUT | M_LOIN;
    localparam logic [26:0] E_MT6 = M_ZHOUT | M_HIIN;
    localparam logic [26:0] E_UT3 = M_GRB | M_ROUT | M_ZLIN;

    function automatic logic [26:0] opf(input logic [4:0] o);
        return {20'd0, o, 2'd0};
    endfunction

    logic [26:0] exp_q[$];
    string       tag_q[$];
    int          total;
    int          bad;
    logic [31:0] cur_ir;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every falling edge, check the bus-driver invariant and compare
    // against the next expectation queued by the stimulus.
    always @(negedge clock) begin
        logic [26:0] got;
        logic [26:0] e;
        string       t;
        logic [4:0]  drv;
        got = {PCout, Zhighout, Zlowout, MDRout, Rout, MARin, PCin, MDRin, IRin, Yin, Rin,
               HIin, LOin, Zhighin, Zlowin, IncPC, Read, Gra, Grb, Grc, opcode, halted, illegal};
        drv = {PCout, Zhighout, Zlowout, MDRout, Rout};
        total++;
        if (!$onehot0(drv)) begin
            bad++;
            $display("FAIL bus_onehot t=%0t drivers=%b required at most one set", $time, drv);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s t=%0t got=%07h expected=%07h", t, $time, got, e);
            end
        end
    end

    // One clock of stimulus: drive inputs just after the edge and queue the
    // outputs expected during that cycle.
    task automatic step(input logic r, input logic mr, input logic c,
                        input logic [26:0] e, input string t);
        @(posedge clock);
        #1;
        run       = r;
        mem_ready = mr;
        clear     = c;
        IR        = cur_ir;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic fetch(input logic [31:0] ir_v, input int waits);
        step(1'b1, 1'b0, 1'b1, E_T0, "T0");
        for (int i = 0; i < waits; i++)
            step(1'b1, 1'b0, 1'b1, (i == 0) ? E_T1F : E_T1W, "T1_wait");
        step(1'b1, 1'b1, 1'b1, (waits == 0) ? E_T1F : E_T1W, "T1_last");
        cur_ir = ir_v;
        step(1'b1, 1'b0, 1'b1, E_T2, "T2");
    endtask

    task automatic exec_bin(input logic [4:0] op);
        step(1'b1, 1'b0, 1'b1, E_BT3, "bin_T3");
        step(1'b1, 1'b0, 1'b1, E_BT4 | opf(op), "bin_T4");
        step(1'b1, 1'b0, 1'b1, E_WB, "bin_T5");
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        cur_ir    = 32'h0;
        IR        = 32'h0;

        // Reset held, then released with run=0: silent RESET then idle T0.
        step(1'b0, 1'b0, 1'b0, 27'd0, "reset_hold");
        step(1'b0, 1'b0, 1'b0, 27'd0, "reset_hold");
        step(1'b0, 1'b0, 1'b1, 27'd0, "reset_release");
        step(1'b0, 1'b0, 1'b1, 27'd0, "t0_idle");
        step(1'b0, 1'b1, 1'b1, 27'd0, "t0_idle");

        // and R1,R2,R3
        fetch(32'h28918000, 0);
        exec_bin(5'b00101);

        // add with 3 memory wait cycles
        fetch({5'b00011, 27'h0}, 3);
        exec_bin(5'b00011);

        // mul R4,R5
        fetch({5'b01111, 4'd4, 4'd5, 19'h0}, 0);
        step(1'b1, 1'b0, 1'b1, E_BT3, "mul_T3");
        step(1'b1, 1'b0, 1'b1, E_BT4 | opf(5'b01111), "mul_T4");
        step(1'b1, 1'b0, 1'b1, E_MT5, "mul_T5");
        step(1'b1, 1'b0, 1'b1, E_MT6, "mul_T6");

        // not R6,R7 then nop
        fetch({5'b10010, 4'd6, 4'd7, 19'h0}, 0);
        step(1'b1, 1'b0, 1'b1, E_UT3 | opf(5'b10010), "not_T3");
        step(1'b1, 1'b0, 1'b1, E_WB, "not_T4");
        fetch({5'b11010, 27'h0}, 0);
        step(1'b1, 1'b0, 1'b1, 27'd0, "nop_T3");

        // illegal opcode, then div with one wait cycle
        fetch({5'b11111, 27'h0}, 0);
        step(1'b1, 1'b0, 1'b1, M_ILLEGAL, "illegal_T3");
        fetch({5'b10000, 4'd2, 4'd3, 19'h0}, 1);
        step(1'b1, 1'b0, 1'b1, E_BT3, "div_T3");
        step(1'b1, 1'b0, 1'b1, E_BT4 | opf(5'b10000), "div_T4");
        step(1'b1, 1'b0, 1'b1, E_MT5, "div_T5");
        step(1'b1, 1'b0, 1'b1, E_MT6, "div_T6");

        // sub aborted by clear in T4, restart with run gating
        fetch({5'b00100, 27'h0}, 0);
        step(1'b1, 1'b0, 1'b1, E_BT3, "sub_T3");
        step(1'b1, 1'b1, 1'b0, 27'd0, "clear_mid_T4");
        step(1'b1, 1'b1, 1'b0, 27'd0, "clear_hold");
        step(1'b0, 1'b0, 1'b1, 27'd0, "reset_release2");
        step(1'b0, 1'b0, 1'b1, 27'd0, "t0_idle2");
        fetch({5'b01011, 27'h0}, 0);
        exec_bin(5'b01011);

        // halt: stays halted regardless of run/mem_ready
        fetch({5'b11011, 27'h0}, 0);
        step(1'b1, 1'b0, 1'b1, 27'd0, "halt_T3");
        for (int i = 0; i < 20; i++)
            step(1'b1, i[0], 1'b1, M_HALTED, "halt_hold");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
